mult_share_sched: RTL and testbench

//   Time-shares one 4x4 unsigned combinational multiplier netlist among NREQ requesters.
//   - Round-robin arbitration over the requesters.
//   - Registers the winner's operands onto the multiplier inputs.
//   - Waits SETTLE cycles for the netlist to settle, then captures the 8-bit product.
//   - Returns the product on a valid/ready response channel tagged with the requester index.
//   - Sits between the requester fabric and any generated multiplier variant, which connects

---
 rtl/mult_sched_pkg.sv | 14 +
 rtl/mult_share_sched_rr_arbiter.sv | 34 +++
 rtl/mult_share_sched.sv | 126 ++++++++++++
 tb/tb_mult_share_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the time-shared 4x4 multiplier scheduler.
package mult_sched_pkg;

  localparam int OPW  = 4;
  localparam int PW   = 8;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] scan;
  int           off;

  // Rotate so bit 0 is the requester at ptr, then take the first set bit.
  always_comb begin
    scan = N'({req, req} >> ptr);
    off  = 0;
    any  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && scan[0]) begin
        any = 1'b1;
        off = k;
      end
      scan = scan >> 1;
    end
    idx = IW'((int'(ptr) + off) % N);
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one external 4x4 combinational multiplier among NREQ requesters with round-robin grants.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*4-1:0] req_x,
  input  logic [NREQ*4-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [OPW-1:0]    mul_x,
  output logic [OPW-1:0]    mul_y,
  input  logic [PW-1:0]     mul_o,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [PW-1:0]     resp_o,
  output logic              busy
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0]   mul_x_q, mul_x_d;
  logic [OPW-1:0]   mul_y_q, mul_y_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [PW-1:0]    resp_o_q, resp_o_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic             resp_valid_q, resp_valid_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Grants depend only on state and req_valid, never on resp_ready or mul_o.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    mul_x_d      = mul_x_q;
    mul_y_d      = mul_y_q;
    id_d         = id_q;
    resp_o_d     = resp_o_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          mul_x_d   = OPW'(req_x >> (int'(arb_idx) * OPW));
          mul_y_d   = OPW'(req_y >> (int'(arb_idx) * OPW));
          id_d      = arb_idx;
          rr_ptr_d  = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
          cnt_d     = CNTW'(SETTLE - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          resp_o_d     = mul_o;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      id_q         <= '0;
      resp_o_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      id_q         <= id_d;
      resp_o_q     <= resp_o_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign resp_o     = resp_o_q;
  assign resp_id    = resp_id_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench: SETTLE=1 instance under directed and random traffic, SETTLE=3 instance swept over all operand pairs.
module tb_mult_share_sched;

  localparam int N  = 4;
  localparam int S1 = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N*4-1:0] req_x = '0, req_y = '0;
  logic [N-1:0]   req_ready;
  logic [3:0]     mul_x, mul_y;
  logic [7:0]     mul_o;
  logic           resp_valid, busy;
  logic           resp_ready = 1'b1;
  logic [1:0]     resp_id;
  logic [7:0]     resp_o;

  logic [N-1:0]   s3_req_valid = '0;
  logic [N*4-1:0] s3_req_x = '0, s3_req_y = '0;
  logic [N-1:0]   s3_req_ready;
  logic [3:0]     s3_mul_x, s3_mul_y;
  logic [7:0]     s3_mul_o;
  logic           s3_resp_valid, s3_busy;
  logic           s3_resp_ready = 1'b1;
  logic [1:0]     s3_resp_id;
  logic [7:0]     s3_resp_o;

  assign mul_o    = {4'b0, mul_x} * {4'b0, mul_y};
  assign s3_mul_o = {4'b0, s3_mul_x} * {4'b0, s3_mul_y};

  mult_share_sched #(.NREQ(N), .SETTLE(S1), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .mul_x(mul_x), .mul_y(mul_y), .mul_o(mul_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_o(resp_o), .busy(busy)
  );

  mult_share_sched #(.NREQ(N), .SETTLE(S3), .IDW(2)) dut_s3 (
    .clk(clk), .rst(rst), .req_valid(s3_req_valid), .req_x(s3_req_x), .req_y(s3_req_y),
    .req_ready(s3_req_ready), .mul_x(s3_mul_x), .mul_y(s3_mul_y), .mul_o(s3_mul_o),
    .resp_valid(s3_resp_valid), .resp_ready(s3_resp_ready), .resp_id(s3_resp_id),
    .resp_o(s3_resp_o), .busy(s3_busy)
  );

  typedef struct { int id; int prod; int due; } exp_t;
  typedef struct { int prod; int gcyc; } exp3_t;
  exp_t  sb[$];
  exp3_t q3[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int s3_done = 0;

  logic       pend_valid [N];
  logic [3:0] pend_x [N];
  logic [3:0] pend_y [N];
  logic [N-1:0] granted = '0;
  logic [N-1:0] auto_mask = '0;
  int  fill_pct = 0;
  bit  allow_drop = 0;
  int  rr_mode = 0;

  // Abstract scheduler model: busy from grant until the response handshake.
  bit         m_busy = 0;
  int         m_due = 0;
  int         mptr = 0;
  logic [3:0] last_x = '0, last_y = '0;
  bit         mon_exp_rv;

  task automatic checkOutput(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic setReq(input int i, input int x, input int y);
    pend_valid[i] = 1'b1;
    pend_x[i]     = x[3:0];
    pend_y[i]     = y[3:0];
  endtask

  task automatic clearReqs();
    for (int i = 0; i < N; i++) pend_valid[i] = 1'b0;
  endtask

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend_valid[i];
      req_x[4*i +: 4]  = pend_x[i];
      req_y[4*i +: 4]  = pend_y[i];
    end
  endtask

  task automatic modelCycle();
    int w;
    int c;
    int px;
    logic [N-1:0] exp_ready;
    w = -1;
    exp_ready = '0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("busy", busy, m_busy);
    checkOutput("mul_x", mul_x, last_x);
    checkOutput("mul_y", mul_y, last_y);
    granted = exp_ready;
    if (w >= 0) begin
      px = int'(pend_x[w]) * int'(pend_y[w]);
      sb.push_back('{w, px, cyc + S1 + 1});
      mptr   = (w + 1) % N;
      last_x = pend_x[w];
      last_y = pend_y[w];
      m_busy = 1;
      m_due  = cyc + S1 + 1;
    end else if (m_busy && cyc >= m_due && resp_ready) begin
      m_busy = 0;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) pend_valid[i] = 1'b0;
      if (auto_mask[i] && !pend_valid[i] && $urandom_range(0, 99) < fill_pct)
        setReq(i, $urandom_range(0, 15), $urandom_range(0, 15));
      else if (allow_drop && pend_valid[i] && $urandom_range(0, 31) == 0)
        pend_valid[i] = 1'b0;
    end
    driveInputs();
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = 1'b0;
    endcase
    @(negedge clk);
    modelCycle();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    m_busy = 0;
    mptr = 0;
    last_x = '0;
    last_y = '0;
    auto_mask = '0;
    clearReqs();
    granted = '0;
    driveInputs();
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mul_x", mul_x, 0);
    checkOutput("rst_mul_y", mul_y, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_resp_o", resp_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Response monitor for the SETTLE=1 instance.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        mon_exp_rv = (sb.size() > 0) && (cyc >= sb[0].due);
        checkOutput("resp_valid", resp_valid, mon_exp_rv);
        if (resp_valid && sb.size() > 0) begin
          checkOutput("resp_o", resp_o, sb[0].prod);
          checkOutput("resp_id", resp_id, sb[0].id);
          if (resp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Response monitor for the SETTLE=3 instance.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && s3_resp_valid) begin
        if (q3.size() == 0) begin
          checkOutput("s3_spurious_resp", 1, 0);
        end else begin
          checkOutput("s3_resp_o", s3_resp_o, q3[0].prod);
          checkOutput("s3_resp_id", s3_resp_id, 2);
          checkOutput("s3_latency", cyc - q3[0].gcyc, S3 + 1);
          void'(q3.pop_front());
          s3_done++;
        end
      end
    end
  end

  initial begin
    #300000;
    failures++;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    clearReqs();
    for (int i = 0; i < N; i++) begin
      pend_x[i] = '0;
      pend_y[i] = '0;
    end
    doReset();

    setReq(0, 13, 11);
    repeat (6) applyStimulus();

    rr_mode = 2;
    setReq(3, 9, 7);
    repeat (2) applyStimulus();
    doReset();
    rr_mode = 2;
    setReq(2, 14, 5);
    repeat (5) applyStimulus();
    doReset();
    rr_mode = 0;

    auto_mask = 4'hF;
    fill_pct  = 100;
    repeat (20) applyStimulus();
    auto_mask = '0;
    clearReqs();
    repeat (5) applyStimulus();

    rr_mode = 2;
    setReq(1, 15, 15);
    applyStimulus();
    setReq(0, 3, 4);
    setReq(2, 7, 8);
    setReq(3, 10, 12);
    repeat (7) applyStimulus();
    rr_mode = 0;
    repeat (14) applyStimulus();

    setReq(2, 6, 6);
    repeat (4) applyStimulus();
    setReq(1, 6, 9);
    repeat (4) applyStimulus();
    setReq(1, 2, 3);
    setReq(2, 4, 5);
    repeat (8) applyStimulus();

    auto_mask  = 4'hF;
    fill_pct   = 30;
    allow_drop = 1;
    rr_mode    = 1;
    repeat (600) applyStimulus();
    auto_mask  = '0;
    allow_drop = 0;
    rr_mode    = 0;
    clearReqs();
    repeat (6) applyStimulus();
    checkOutput("sb_drained", sb.size(), 0);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(posedge clk);
        #1;
        s3_req_valid = 4'b0100;
        s3_req_x = '0;
        s3_req_y = '0;
        s3_req_x[11:8] = x[3:0];
        s3_req_y[11:8] = y[3:0];
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
          @(negedge clk);
          if (s3_req_ready != '0) begin
            got = 1;
            checkOutput("s3_req_ready", s3_req_ready, 4'b0100);
            q3.push_back('{x * y, cyc});
          end
        end
        if (!got) checkOutput("s3_grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        s3_req_valid = '0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
          @(negedge clk);
          #2;
          if (q3.size() == 0) got = 1;
        end
        if (!got) begin
          checkOutput("s3_resp_timeout", 0, 1);
          q3.delete();
        end
      end
    end
    checkOutput("s3_count", s3_done, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
